fp_addsub_ctrl: RTL and testbench
=================================

# fp_addsub_ctrl

Sequencing controller for the FP adder/subtractor datapath in the RV64F FPU. Accepts one operation at a time over a valid/ready handshake and steps the datapath through LOAD, ALIGN, OPERATION, NORMALIZE and ROUND. It issues one-hot stage enables and the alignment-shift control, and presents the result under output backpressure. It holds no arithmetic of its own; all mantissa and exponent logic stays in the datapath.

## Interface
- Size, 32, FP width (32 or 64); ExpSize = 8/11, MantSize = 23/52 derived from it
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  controller can accept
- sub  in  1  requested op (1 = subtract), sampled on accept
- exp_diff  in  ExpSize  |exp_a − exp_b| from datapath, valid in ALIGN
- swap  in  1  operand_b has larger magnitude, valid in ALIGN
- carry  in  1  mantissa adder carry, valid in OPERATION
- leading_zeros  in  $clog2(MantSize+4)  from normaliser, valid in NORMALIZE
- round_ovf  in  1  rounding overflowed mantissa, valid in ROUND
- special  in  1  NaN/Inf/zero operand detected, valid in LOAD
- load_en, align_en, op_en, norm_en, round_en  out  1 each  one-hot stage enables
- swap_sel  out  1  registered swap, held from ALIGN until next accept
- shift_amt  out  $clog2(MantSize+4)  alignment shift, saturated
- sticky_all  out  1  exp_diff ≥ MantSize+4; entire smaller mantissa folds into sticky
- sub_q  out  1  registered sub
- out_valid  out  1  result ready
- out_ready  in  1  consumer accepts result
- busy  out  1  state ≠ IDLE

## Operation
- States: IDLE, LOAD, ALIGN, OPERATION, NORMALIZE, ROUND, DONE.
- IDLE: in_ready=1. If in_valid, latch sub into sub_q and go to LOAD.
- LOAD: load_en=1.
  - Next is DONE if special (and bypass compiled in).
  - Otherwise next is ALIGN.
- ALIGN: align_en=1.
  - Register swap_sel.
  - shift_amt = min(exp_diff, MantSize+3).
  - sticky_all = exp_diff ≥ MantSize+4.
  - Next is OPERATION.
- OPERATION: op_en=1. Next is NORMALIZE.
- NORMALIZE: norm_en=1. Next is ROUND.
- ROUND: round_en=1.
  - If round_ovf and renorm flag clear: set renorm flag, next is NORMALIZE.
  - Otherwise next is DONE.
  - At most one renormalisation per op; the renorm flag clears on accept.
- DONE: out_valid=1.
  - If out_ready: next is IDLE.
  - Otherwise hold DONE; all enables stay 0.
- Stage enables are mutually exclusive, exactly one cycle per visit, and all 0 in IDLE and DONE.
- in_valid outside IDLE is ignored. in_ready=0 there; no queueing.

## Timing
- Reset (async, rst_n=0):
  - state=IDLE.
  - All enables, swap_sel, shift_amt, sticky_all, sub_q, out_valid, busy = 0.
  - in_ready=1 as soon as rst_n deasserts.
- All outputs are decoded from registered state or are registers; no input-to-output combinational paths except in_ready/out_valid, which are state decodes.
- Latency, accept edge to out_valid: 6 cycles nominal, 8 with renormalisation, 2 with special bypass.
- No back-to-back: the earliest next accept is the cycle after the DONE handshake. Throughput is 1 op per 7 cycles.
- Reset asserted mid-operation: abort immediately to IDLE. No out_valid is produced for the aborted op.
- exp_diff = MantSize+3: shift_amt = MantSize+3, sticky_all=0. exp_diff = MantSize+4: sticky_all=1.

## Configuration
- FP_ADDSUB_SPECIAL_BYPASS_EN defined:
  - special in LOAD jumps to DONE.
  - The datapath's special-result mux drives the result.
- Undefined:
  - special is ignored.
  - All ops take the full path.
  - The special port remains present but unused.

## Structure
- Shared package fpu_pkg:
  - State enum fp_addsub_state_t.
  - ExpSize/MantSize derivation functions.
  - Constant ALIGN_SAT = MantSize+3.
- Natural sub-module: fp_align_sat, combinational shift_amt/sticky_all saturation.
- Everything else stays in one FSM module.

## Test plan
- Reset mid-ROUND, then release: busy=0, in_ready=1, no out_valid. A new op accepted afterwards completes in 6 cycles.
- Size=32, exp_diff=5, no round_ovf: one pulse each of load/align/op/norm/round_en in order. out_valid 6 cycles after accept, shift_amt=5, sticky_all=0.
- Size=64, exp_diff=60: shift_amt=55, sticky_all=1. exp_diff=55: shift_amt=55, sticky_all=0.
- round_ovf=1 on both ROUND visits: exactly one extra NORMALIZE/ROUND pair, out_valid at cycle 8.
- out_ready held 0 for 4 cycles in DONE: out_valid stays 1, all enables 0, in_ready=0. IDLE is entered the cycle after out_ready=1.
- special=1, with and without FP_ADDSUB_SPECIAL_BYPASS_EN: out_valid at cycle 2, versus the normal 6-cycle sequence.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU types and format-size helpers for the add/sub controller
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ALIGN,
    ST_OPERATION,
    ST_NORMALIZE,
    ST_ROUND,
    ST_DONE
  } fp_addsub_state_t;

  function automatic int exp_size(input int size);
    return (size == 64) ? 11 : 8;
  endfunction

  function automatic int mant_size(input int size);
    return (size == 64) ? 52 : 23;
  endfunction

  // Alignment shifts beyond mantissa + guard/round/sticky saturate here (ALIGN_SAT)
  function automatic int align_sat(input int size);
    return mant_size(size) + 3;
  endfunction

  function automatic int shamt_w(input int size);
    return $clog2(mant_size(size) + 4);
  endfunction

endpackage

// File: rtl/fp_align_sat.sv
// rtl/fp_align_sat.sv - saturates the exponent difference into a shift amount and whole-mantissa sticky flag
module fp_align_sat #(
  parameter int ExpW = 8,
  parameter int ShW  = 5,
  parameter int Sat  = 26
) (
  input  logic [ExpW-1:0] exp_diff_i,
  output logic [ShW-1:0]  shift_amt_o,
  output logic            sticky_all_o
);

  localparam logic [ExpW-1:0] SAT_E = ExpW'(Sat);
  localparam logic [ShW-1:0]  SAT_S = ShW'(Sat);

  always_comb begin
    shift_amt_o  = SAT_S;
    sticky_all_o = 1'b0;
    if (exp_diff_i < SAT_E) begin
      shift_amt_o = exp_diff_i[ShW-1:0];
    end
    // One past the saturation point pushes every mantissa bit out into sticky
    if (exp_diff_i > SAT_E) begin
      sticky_all_o = 1'b1;
    end
  end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// rtl/fp_addsub_ctrl.sv - FP add/sub sequencing FSM; FP_ADDSUB_SPECIAL_BYPASS_EN enables LOAD->DONE on special operands
module fp_addsub_ctrl
  import fpu_pkg::*;
#(
  parameter int Size = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic                       sub_i,
  input  logic [exp_size(Size)-1:0]  exp_diff_i,
  input  logic                       swap_i,
  input  logic                       carry_i,
  input  logic [shamt_w(Size)-1:0]   leading_zeros_i,
  input  logic                       round_ovf_i,
  input  logic                       special_i,
  output logic                       load_en_o,
  output logic                       align_en_o,
  output logic                       op_en_o,
  output logic                       norm_en_o,
  output logic                       round_en_o,
  output logic                       swap_sel_o,
  output logic [shamt_w(Size)-1:0]   shift_amt_o,
  output logic                       sticky_all_o,
  output logic                       sub_q_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int ExpSize   = exp_size(Size);
  localparam int ShW       = shamt_w(Size);
  localparam int ALIGN_SAT = align_sat(Size);

  fp_addsub_state_t state_q, state_d;
  logic             sub_q, swap_q, sticky_q, renorm_q;
  logic [ShW-1:0]   shift_q;
  logic [ShW-1:0]   shift_c;
  logic             sticky_c;

  fp_align_sat #(
    .ExpW (ExpSize),
    .ShW  (ShW),
    .Sat  (ALIGN_SAT)
  ) u_align_sat (
    .exp_diff_i   (exp_diff_i),
    .shift_amt_o  (shift_c),
    .sticky_all_o (sticky_c)
  );

`ifdef FP_ADDSUB_SPECIAL_BYPASS_EN
  logic unused_inputs;
  assign unused_inputs = ^{carry_i, leading_zeros_i};
`else
  logic unused_inputs;
  assign unused_inputs = ^{carry_i, leading_zeros_i, special_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation context: sub latched on accept, alignment results captured in ALIGN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q    <= 1'b0;
      swap_q   <= 1'b0;
      shift_q  <= '0;
      sticky_q <= 1'b0;
      renorm_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && in_valid_i) begin
        sub_q    <= sub_i;
        renorm_q <= 1'b0;
      end
      if (state_q == ST_ALIGN) begin
        swap_q   <= swap_i;
        shift_q  <= shift_c;
        sticky_q <= sticky_c;
      end
      if (state_q == ST_ROUND && round_ovf_i && !renorm_q) begin
        renorm_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (in_valid_i) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_ALIGN;
`ifdef FP_ADDSUB_SPECIAL_BYPASS_EN
        if (special_i) state_d = ST_DONE;
`endif
      end
      ST_ALIGN:     state_d = ST_OPERATION;
      ST_OPERATION: state_d = ST_NORMALIZE;
      ST_NORMALIZE: state_d = ST_ROUND;
      ST_ROUND:     state_d = (round_ovf_i && !renorm_q) ? ST_NORMALIZE : ST_DONE;
      ST_DONE:      if (out_ready_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o   = (state_q == ST_IDLE);
    load_en_o    = (state_q == ST_LOAD);
    align_en_o   = (state_q == ST_ALIGN);
    op_en_o      = (state_q == ST_OPERATION);
    norm_en_o    = (state_q == ST_NORMALIZE);
    round_en_o   = (state_q == ST_ROUND);
    out_valid_o  = (state_q == ST_DONE);
    busy_o       = (state_q != ST_IDLE);
    swap_sel_o   = swap_q;
    shift_amt_o  = shift_q;
    sticky_all_o = sticky_q;
    sub_q_o      = sub_q;
  end

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// tb/tb_fp_addsub_ctrl.sv - self-checking bench for fp_addsub_ctrl at Size 32 and 64 in lockstep
module tb_fp_addsub_ctrl;

`ifdef FP_ADDSUB_SPECIAL_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, sub = 1'b0, swap = 1'b0, carry = 1'b0;
  logic        round_ovf = 1'b0, special = 1'b0, out_ready = 1'b1;
  logic [7:0]  e32 = '0;
  logic [10:0] e64 = '0;
  logic [4:0]  lz32 = '0;
  logic [5:0]  lz64 = '0;

  logic in_ready32, load32, align32, op32, norm32, round32, swap_sel32, sticky32, sub_q32, out_valid32, busy32;
  logic in_ready64, load64, align64, op64, norm64, round64, swap_sel64, sticky64, sub_q64, out_valid64, busy64;
  logic [4:0] shift32;
  logic [5:0] shift64;

  always #5 clk = ~clk;

  fp_addsub_ctrl #(.Size(32)) dut32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready32),
    .sub_i(sub), .exp_diff_i(e32), .swap_i(swap), .carry_i(carry),
    .leading_zeros_i(lz32), .round_ovf_i(round_ovf), .special_i(special),
    .load_en_o(load32), .align_en_o(align32), .op_en_o(op32), .norm_en_o(norm32),
    .round_en_o(round32), .swap_sel_o(swap_sel32), .shift_amt_o(shift32),
    .sticky_all_o(sticky32), .sub_q_o(sub_q32), .out_valid_o(out_valid32),
    .out_ready_i(out_ready), .busy_o(busy32)
  );

  fp_addsub_ctrl #(.Size(64)) dut64 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready64),
    .sub_i(sub), .exp_diff_i(e64), .swap_i(swap), .carry_i(carry),
    .leading_zeros_i(lz64), .round_ovf_i(round_ovf), .special_i(special),
    .load_en_o(load64), .align_en_o(align64), .op_en_o(op64), .norm_en_o(norm64),
    .round_en_o(round64), .swap_sel_o(swap_sel64), .shift_amt_o(shift64),
    .sticky_all_o(sticky64), .sub_q_o(sub_q64), .out_valid_o(out_valid64),
    .out_ready_i(out_ready), .busy_o(busy64)
  );

  logic [5:0] v32, v64;
  assign v32 = {out_valid32, round32, norm32, op32, align32, load32};
  assign v64 = {out_valid64, round64, norm64, op64, align64, load64};

  int passed = 0;
  int total  = 0;

  // Model of the registered context outputs
  bit       m_sub, m_swap, m_sticky32, m_sticky64;
  int       m_shift32, m_shift64;

  int          lat;
  logic [63:0] sig;
  bit          hold_ok, idle_after;
  int          e_lat;
  logic [63:0] e_sig;

  function automatic int decode(input logic [5:0] v);
    if ($countones(v) > 1) return 7;
    for (int i = 0; i < 6; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  // 1..5 = LOAD..ROUND enable, 6 = DONE, 7 = multiple hot, 8 = the two sizes disagree
  function automatic int cur_code();
    int c;
    c = decode(v64);
    if (decode(v32) != c) c = 8;
    return c;
  endfunction

  task automatic model_reset();
    m_sub = 0; m_swap = 0; m_sticky32 = 0; m_sticky64 = 0; m_shift32 = 0; m_shift64 = 0;
  endtask

  task automatic model_op(input bit s, sw, ovf, sp, input int d32, input int d64);
    int seq[$];
    m_sub = s;
    if (sp && BYPASS) begin
      seq = '{1, 6};
    end else begin
      seq = '{1, 2, 3, 4, 5};
      if (ovf) begin seq.push_back(4); seq.push_back(5); end
      seq.push_back(6);
      m_swap     = sw;
      m_shift32  = (d32 < 26) ? d32 : 26;
      m_sticky32 = (d32 >= 27);
      m_shift64  = (d64 < 55) ? d64 : 55;
      m_sticky64 = (d64 >= 56);
    end
    e_lat = seq.size();
    e_sig = '0;
    foreach (seq[i]) e_sig = {e_sig[59:0], 4'(seq[i])};
  endtask

  task automatic do_op(input bit s, sw, ovf, sp, input int d32, input int d64, input int hold);
    @(negedge clk);
    sub = s; swap = sw; round_ovf = ovf; special = sp; carry = 1'($urandom);
    e32 = 8'(d32); e64 = 11'(d64);
    out_ready = (hold == 0); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1; sig = '0; hold_ok = 1; idle_after = 0;
    for (int c = 1; c <= 20; c++) begin
      int k;
      k = cur_code();
      sig = {sig[59:0], 4'(k)};
      if (k == 6) begin lat = c; break; end
      @(negedge clk);
    end
    if (lat > 0) begin
      for (int h = 0; h < hold; h++) begin
        if (!(out_valid64 && out_valid32 && !in_ready64 && !in_ready32 &&
              v64[4:0] == 5'b0 && v32[4:0] == 5'b0)) hold_ok = 0;
        @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      idle_after = in_ready64 && in_ready32 && !busy64 && !out_valid64;
    end
    model_op(s, sw, ovf, sp, d32, d64);
  endtask

  task automatic check_ctx(input string tag);
    total++;
    if (shift32 !== 5'(m_shift32) || sticky32 !== m_sticky32) $display("FAIL %s ctx32: shift=%0d sticky=%0b want shift=%0d sticky=%0b", tag, shift32, sticky32, m_shift32, m_sticky32);
    else passed++;
    total++;
    if (shift64 !== 6'(m_shift64) || sticky64 !== m_sticky64) $display("FAIL %s ctx64: shift=%0d sticky=%0b want shift=%0d sticky=%0b", tag, shift64, sticky64, m_shift64, m_sticky64);
    else passed++;
    total++;
    if (swap_sel64 !== m_swap || swap_sel32 !== m_swap || sub_q64 !== m_sub || sub_q32 !== m_sub)
      $display("FAIL %s swap/sub: swap=%0b sub=%0b want swap=%0b sub=%0b", tag, swap_sel64, sub_q64, m_swap, m_sub);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    total++;
    if (in_ready64 !== 1'b1 || busy64 !== 1'b0 || in_ready32 !== 1'b1 || busy32 !== 1'b0)
      $display("FAIL reset_ready: in_ready=%0b busy=%0b want 1/0", in_ready64, busy64);
    else passed++;
    total++;
    if (v64 !== 6'b0 || v32 !== 6'b0) $display("FAIL reset_enables: got %b/%b want 000000", v64, v32);
    else passed++;
    check_ctx("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    do_op(1, 1, 0, 0, 5, 5, 0);
    total++;
    if (lat !== 6) $display("FAIL nominal_latency: got %0d want 6", lat); else passed++;
    total++;
    if (sig !== e_sig) $display("FAIL nominal_sequence: got %h want %h", sig, e_sig); else passed++;
    check_ctx("nominal");
    total++;
    if (idle_after !== 1'b1) $display("FAIL nominal_idle: got %0b want 1", idle_after); else passed++;
  endtask

  task automatic test_saturation();
    int d32s[3] = '{26, 27, 255};
    int d64s[3] = '{55, 56, 60};
    for (int i = 0; i < 3; i++) begin
      do_op(0, i[0], 0, 0, d32s[i], d64s[i], 0);
      total++;
      if (lat !== e_lat) $display("FAIL sat_latency: got %0d want %0d", lat, e_lat); else passed++;
      check_ctx("saturation");
    end
  endtask

  task automatic test_renorm();
    do_op(0, 0, 1, 0, 3, 3, 0);
    total++;
    if (lat !== 8) $display("FAIL renorm_latency: got %0d want 8", lat); else passed++;
    total++;
    if (sig !== e_sig) $display("FAIL renorm_sequence: got %h want %h", sig, e_sig); else passed++;
  endtask

  task automatic test_backpressure();
    do_op(1, 0, 0, 0, 10, 40, 4);
    total++;
    if (hold_ok !== 1'b1) $display("FAIL backpressure_hold: got %0b want 1", hold_ok); else passed++;
    total++;
    if (idle_after !== 1'b1) $display("FAIL backpressure_release: got %0b want 1", idle_after); else passed++;
    check_ctx("backpressure");
  endtask

  task automatic test_special();
    do_op(0, 1, 0, 1, 7, 9, 0);
    total++;
    if (lat !== (BYPASS ? 2 : 6)) $display("FAIL special_latency: got %0d want %0d", lat, BYPASS ? 2 : 6); else passed++;
    total++;
    if (sig !== e_sig) $display("FAIL special_sequence: got %h want %h", sig, e_sig); else passed++;
    check_ctx("special");
  endtask

  task automatic test_back_to_back();
    int loads[$];
    @(negedge clk);
    special = 0; round_ovf = 0; out_ready = 1; swap = 0; sub = 0; e32 = 8'd1; e64 = 11'd2;
    in_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (load64 && load32) loads.push_back(c);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && busy64; c++) @(negedge clk);
    model_op(0, 0, 0, 0, 1, 2);
    total++;
    if (loads.size() < 3 || loads[1] - loads[0] != 7 || loads[2] - loads[1] != 7)
      $display("FAIL back_to_back_spacing: got %0d loads first=%0d second=%0d want spacing 7", loads.size(),
               loads.size() > 0 ? loads[0] : -1, loads.size() > 1 ? loads[1] : -1);
    else passed++;
    total++;
    if (busy64 !== 1'b0) $display("FAIL back_to_back_drain: busy=%0b want 0", busy64); else passed++;
  endtask

  task automatic test_reset_mid_round();
    bit seen_round, seen_valid;
    @(negedge clk);
    special = 0; round_ovf = 0; out_ready = 1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    seen_round = 0;
    for (int c = 0; c < 10 && !seen_round; c++) begin
      if (round64) seen_round = 1; else @(negedge clk);
    end
    total++;
    if (!seen_round) $display("FAIL midround_reach: round_en=%0b want 1", round64); else passed++;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (busy64 !== 1'b0 || in_ready64 !== 1'b1 || out_valid64 !== 1'b0 || v32 !== 6'b0)
      $display("FAIL midround_abort: busy=%0b in_ready=%0b out_valid=%0b want 0/1/0", busy64, in_ready64, out_valid64);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid64 || out_valid32 || busy64) seen_valid = 1;
    end
    total++;
    if (seen_valid) $display("FAIL midround_no_result: got activity=1 want 0"); else passed++;
    do_op(1, 0, 0, 0, 4, 4, 0);
    total++;
    if (lat !== 6) $display("FAIL midround_next_latency: got %0d want 6", lat); else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit s, sw, ovf, sp;
      int d32, d64;
      s   = 1'($urandom);
      sw  = 1'($urandom);
      ovf = ($urandom_range(0, 3) == 0);
      sp  = ($urandom_range(0, 4) == 0);
      d32 = ($urandom_range(0, 1) == 1) ? $urandom_range(24, 29) : $urandom_range(0, 255);
      d64 = ($urandom_range(0, 1) == 1) ? $urandom_range(53, 58) : $urandom_range(0, 2047);
      do_op(s, sw, ovf, sp, d32, d64, $urandom_range(0, 2));
      total++;
      if (lat !== e_lat || sig !== e_sig)
        $display("FAIL random_seq[%0d]: lat=%0d sig=%h want lat=%0d sig=%h", i, lat, sig, e_lat, e_sig);
      else passed++;
      check_ctx("random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_renorm();
    test_backpressure();
    test_special();
    test_back_to_back();
    test_reset_mid_round();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
